// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the context-switching register file.
package reg_file_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } ctx_state_t;

  localparam int DATA_W_DEFAULT = 8;
  localparam int DEPTH_DEFAULT  = 8;

endpackage

// File: rtl/reg_file_ctx_fsm.sv
// Save/restore sequencer: walks the copy index over every register once,
// reports busy/done and gates the writeback port while a copy runs.
module reg_file_ctx_fsm
  import reg_file_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          save_req_i,
  input  logic          restore_req_i,
  output logic          ctx_busy_o,
  output logic          ctx_done_o,
  output logic          wr_ready_o,
  output logic          save_stb_o,
  output logic          rest_stb_o,
  output logic [AW-1:0] copy_idx_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  ctx_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          done_q, done_d;

  // State, copy index and the registered completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next state: requests only matter in IDLE, SAVE beats RESTORE, and the
  // copy ends after the last index so the done pulse lands in the first IDLE cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (save_req_i)         state_d = SAVE;
        else if (restore_req_i) state_d = RESTORE;
      end
      SAVE, RESTORE: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign ctx_busy_o = (state_q != IDLE);
  assign ctx_done_o = done_q;
  assign wr_ready_o = (state_q == IDLE);
  assign save_stb_o = (state_q == SAVE);
  assign rest_stb_o = (state_q == RESTORE);
  assign copy_idx_o = idx_q;

endmodule

// File: rtl/reg_file_ctx.sv
// Parametrised register file with a shadow bank for interrupt context
// switching: two combinational read ports, one write port, a branch tap and
// a one-register-per-cycle save/restore engine.
// Build option: define REG_FILE_BYPASS_EN to forward same-cycle write data
// onto the read ports and the branch tap.
module reg_file_ctx
  import reg_file_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEFAULT,
  parameter  int DEPTH  = DEPTH_DEFAULT,
  parameter  int BR_IDX = DEPTH - 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] branch_out,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              ctx_busy,
  output logic              ctx_done
);

  logic [DEPTH-1:0][DATA_W-1:0] main_q, main_d;
  logic [DEPTH-1:0][DATA_W-1:0] shadow_q, shadow_d;

  logic          save_stb, rest_stb;
  logic [AW-1:0] copy_idx;
  logic          wr_fire;

  reg_file_ctx_fsm #(.DEPTH(DEPTH)) u_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .save_req_i    (save_req),
    .restore_req_i (restore_req),
    .ctx_busy_o    (ctx_busy),
    .ctx_done_o    (ctx_done),
    .wr_ready_o    (wr_ready),
    .save_stb_o    (save_stb),
    .rest_stb_o    (rest_stb),
    .copy_idx_o    (copy_idx)
  );

  // Writes are dropped, not queued, while a copy owns the banks.
  assign wr_fire = wr_en && wr_ready;

  // Next bank contents. Restore and writeback never coincide since
  // wr_ready is low outside IDLE; restore is listed first regardless.
  always_comb begin
    main_d   = main_q;
    shadow_d = shadow_q;
    if (save_stb) shadow_d[copy_idx] = main_q[copy_idx];
    if (rest_stb)     main_d[copy_idx] = shadow_q[copy_idx];
    else if (wr_fire) main_d[wr_addr]  = wr_data;
  end

  // Both banks clear on reset, which also aborts any copy in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      shadow_q <= '0;
    end else begin
      main_q   <= main_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  // Forward the accepted write straight to any port addressing it.
  always_comb begin
    rd_data_a  = main_q[rd_addr_a];
    rd_data_b  = main_q[rd_addr_b];
    branch_out = main_q[BR_IDX];
    if (wr_fire && (wr_addr == rd_addr_a))      rd_data_a  = wr_data;
    if (wr_fire && (wr_addr == rd_addr_b))      rd_data_b  = wr_data;
    if (wr_fire && (wr_addr == AW'(BR_IDX)))    branch_out = wr_data;
  end
`else
  // Plain reads: new data is visible only after the write edge.
  always_comb begin
    rd_data_a  = main_q[rd_addr_a];
    rd_data_b  = main_q[rd_addr_b];
    branch_out = main_q[BR_IDX];
  end
`endif

endmodule

// File: tb/tb_reg_file_ctx.sv
// Scoreboard bench for reg_file_ctx (DEPTH=8, DATA_W=8): stimulus pushes
// expected values, a negedge monitor pops and compares them.
module tb_reg_file_ctx;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int AW = 3;

  localparam int S_RDA  = 0;
  localparam int S_RDB  = 1;
  localparam int S_BR   = 2;
  localparam int S_RDY  = 3;
  localparam int S_BUSY = 4;
  localparam int S_DONE = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic [AW-1:0] rd_addr_a = '0;
  logic [DW-1:0] rd_data_a;
  logic [AW-1:0] rd_addr_b = '0;
  logic [DW-1:0] rd_data_b;
  logic [DW-1:0] branch_out;
  logic          save_req = 1'b0;
  logic          restore_req = 1'b0;
  logic          ctx_busy;
  logic          ctx_done;

  reg_file_ctx #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .rd_addr_a   (rd_addr_a),
    .rd_data_a   (rd_data_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_b   (rd_data_b),
    .branch_out  (branch_out),
    .save_req    (save_req),
    .restore_req (restore_req),
    .ctx_busy    (ctx_busy),
    .ctx_done    (ctx_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int            sel_q[$];
  logic [DW-1:0] exp_q[$];
  string         nm_q[$];

  task automatic expect_v(input int sel, input logic [DW-1:0] v, input string nm);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    nm_q.push_back(nm);
  endtask

  function automatic logic [DW-1:0] observe(input int sel);
    case (sel)
      S_RDA:   return rd_data_a;
      S_RDB:   return rd_data_b;
      S_BR:    return branch_out;
      S_RDY:   return {7'd0, wr_ready};
      S_BUSY:  return {7'd0, ctx_busy};
      default: return {7'd0, ctx_done};
    endcase
  endfunction

  // Monitor: drain every expectation queued during this cycle.
  int            m_sel;
  logic [DW-1:0] m_exp, m_act;
  string         m_nm;
  always @(negedge clk) begin
    while (sel_q.size() > 0) begin
      m_sel = sel_q.pop_front();
      m_exp = exp_q.pop_front();
      m_nm  = nm_q.pop_front();
      m_act = observe(m_sel);
      n_cmp++;
      if (m_act !== m_exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%02h expected 0x%02h", m_nm, m_act, m_exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic chk_reg(input int a, input logic [DW-1:0] d, input string nm);
    rd_addr_a = AW'(a);
    rd_addr_b = AW'(a);
    expect_v(S_RDA, d, {nm, "_a"});
    expect_v(S_RDB, d, {nm, "_b"});
    cyc();
  endtask

  task automatic chk_ctl(input logic busy, input logic done, input string nm);
    expect_v(S_BUSY, {7'd0, busy}, {nm, "_busy"});
    expect_v(S_DONE, {7'd0, done}, {nm, "_done"});
    expect_v(S_RDY,  {7'd0, ~busy}, {nm, "_ready"});
  endtask

  // Eight busy cycles, one done cycle, then quiet. With inject set, a write
  // and a restore request are attempted mid-copy and must both be ignored.
  task automatic copy_window(input bit inject, input string nm);
    for (int i = 0; i < DP; i++) begin
      if (inject) begin
        wr_en       = (i == 2);
        wr_addr     = 3'd2;
        wr_data     = 8'h55;
        restore_req = (i >= 4 && i <= 6);
      end
      chk_ctl(1'b1, 1'b0, nm);
      cyc();
    end
    wr_en       = 1'b0;
    restore_req = 1'b0;
    chk_ctl(1'b0, 1'b1, {nm, "_end"});
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk_ctl(1'b0, 1'b0, {nm, "_after"});
      cyc();
    end
  endtask

  initial begin
    // Reset for two cycles.
    cyc();
    cyc();
    rst_n = 1'b1;
    chk_ctl(1'b0, 1'b0, "reset");
    expect_v(S_BR, 8'h00, "reset_br");
    for (int i = 0; i < DP; i++) chk_reg(i, 8'h00, "reset_rd");

    // Write r3=A5; same-cycle view depends on the bypass build.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; rd_addr_a = 3'd3;
`ifdef REG_FILE_BYPASS_EN
    expect_v(S_RDA, 8'hA5, "wr3_same_cycle");
`else
    expect_v(S_RDA, 8'h00, "wr3_same_cycle");
`endif
    cyc();
    wr_en = 1'b0;
    expect_v(S_RDA, 8'hA5, "wr3_next_cycle");
    cyc();

    // Branch tap follows r7.
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h01;
`ifdef REG_FILE_BYPASS_EN
    expect_v(S_BR, 8'h01, "br_same_cycle");
`else
    expect_v(S_BR, 8'h00, "br_same_cycle");
`endif
    cyc();
    wr_en = 1'b0;
    rd_addr_a = 3'd7; rd_addr_b = 3'd3;
    expect_v(S_BR,  8'h01, "br_next");
    expect_v(S_RDA, 8'h01, "dual_rd_a");
    expect_v(S_RDB, 8'hA5, "dual_rd_b");
    cyc();

    // Fill 0x10..0x17 and save; mid-copy write and restore must be ignored.
    for (int i = 0; i < DP; i++) wr(i, 8'(8'h10 + i));
    save_req = 1'b1;
    chk_ctl(1'b0, 1'b0, "save_req");
    cyc();
    save_req = 1'b0;
    copy_window(1'b1, "save");
    chk_reg(2, 8'h12, "r2_dropped_write");
    chk_reg(5, 8'h15, "main_after_save");

    // Clobber, then restore.
    for (int i = 0; i < DP; i++) wr(i, 8'hFF);
    chk_reg(4, 8'hFF, "clobbered");
    expect_v(S_BR, 8'hFF, "br_clobbered");
    restore_req = 1'b1;
    cyc();
    restore_req = 1'b0;
    copy_window(1'b0, "restore");
    for (int i = 0; i < DP; i++) chk_reg(i, 8'(8'h10 + i), "restored");
    expect_v(S_BR, 8'h17, "br_restored");
    cyc();

    // Simultaneous requests: SAVE wins, main untouched.
    wr(0, 8'h20);
    wr(1, 8'h21);
    save_req = 1'b1; restore_req = 1'b1;
    cyc();
    save_req = 1'b0; restore_req = 1'b0;
    copy_window(1'b0, "both_req");
    chk_reg(0, 8'h20, "both_main_r0");
    chk_reg(1, 8'h21, "both_main_r1");
    wr(0, 8'h33);
    restore_req = 1'b1;
    cyc();
    restore_req = 1'b0;
    copy_window(1'b0, "restore2");
    chk_reg(0, 8'h20, "shadow_r0_saved");
    chk_reg(1, 8'h21, "shadow_r1_saved");

    // Reset in copy cycle 4 aborts the save and clears both banks.
    save_req = 1'b1;
    cyc();
    save_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_ctl(1'b1, 1'b0, "abort_pre");
      cyc();
    end
    rst_n = 1'b0;
    #1;
    rd_addr_a = 3'd0; rd_addr_b = 3'd3;
    chk_ctl(1'b0, 1'b0, "abort_in_reset");
    expect_v(S_RDA, 8'h00, "abort_rd_a");
    expect_v(S_RDB, 8'h00, "abort_rd_b");
    expect_v(S_BR,  8'h00, "abort_br");
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < DP; i++) begin
      chk_ctl(1'b0, 1'b0, "abort_after");
      chk_reg(i, 8'h00, "abort_main");
    end
    wr(0, 8'h77);
    restore_req = 1'b1;
    cyc();
    restore_req = 1'b0;
    copy_window(1'b0, "restore_zero");
    chk_reg(0, 8'h00, "shadow_cleared");

    cyc();
    if (sel_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sel_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
